// File: rtl/sevenseg_scan_decoder.sv
// rtl/sevenseg_scan_decoder.sv - 7-segment scan bus reader: debounce, decode, frame assembly
module sevenseg_scan_decoder #(
    parameter int DIGITS = 4,
    parameter int STABLE = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            segments,
    input  logic [DIGITS-1:0]     digit_sel,
    output logic [4*DIGITS-1:0]   out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_err,
    output logic                  overrun
);

    typedef enum logic {IDLE, COLLECT} state_t;

    localparam logic [3:0] STABLE_M1 = 4'(STABLE - 1);

    state_t                state;
    logic [6:0]            seg_r;
    logic [DIGITS-1:0]     sel_r;
    logic [3:0]            cnt;
    logic [DIGITS-1:0]     seen;
    logic                  ferr;
    logic [4*DIGITS-1:0]   slots;

    logic [4:0]            dec;
    logic                  onehot;
    logic                  capture;
    logic                  complete;
    logic                  out_free;
    logic [DIGITS-1:0]     seen_n;
    logic                  ferr_n;
    logic [4*DIGITS-1:0]   slots_n;

    // Returns {invalid, code}.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h7E:   decode = 5'h00;
            7'h30:   decode = 5'h01;
            7'h6D:   decode = 5'h02;
            7'h79:   decode = 5'h03;
            7'h33:   decode = 5'h04;
            7'h5B:   decode = 5'h05;
            7'h5F:   decode = 5'h06;
            7'h70:   decode = 5'h07;
            7'h7F:   decode = 5'h08;
            7'h7B:   decode = 5'h09;
            7'h00:   decode = 5'h0F;
            default: decode = 5'h1E;
        endcase
    endfunction

    // cnt is kept aligned with the registered sample: it is the run length of
    // the sample currently held in seg_r/sel_r, minus one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r <= '0;
            sel_r <= '0;
            cnt   <= '0;
        end else begin
            seg_r <= segments;
            sel_r <= digit_sel;
            if ({digit_sel, segments} == {sel_r, seg_r}) begin
                if (cnt != 4'hF)
                    cnt <= cnt + 4'd1;
            end else begin
                cnt <= '0;
            end
        end
    end

    always_comb begin
        dec      = decode(seg_r);
        onehot   = (sel_r != '0) && ((sel_r & (sel_r - DIGITS'(1))) == '0);
        capture  = (cnt == STABLE_M1) && onehot && ((seen & sel_r) == '0);
        seen_n   = seen | (capture ? sel_r : '0);
        ferr_n   = ferr | (capture & dec[4]);
        slots_n  = slots;
        for (int i = 0; i < DIGITS; i++) begin
            if (capture && sel_r[i])
                slots_n[4*i +: 4] = dec[3:0];
        end
        complete = capture && (&seen_n);
        out_free = !out_valid || out_ready;
    end

    // Completion is resolved on the edge of the final capture so the frame
    // reaches out_data without an extra pipeline stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            seen      <= '0;
            ferr      <= 1'b0;
            slots     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            slots   <= slots_n;
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (complete) begin
                if (out_free) begin
                    out_data  <= slots_n;
                    out_valid <= 1'b1;
                    out_err   <= ferr_n;
                end else begin
                    overrun <= 1'b1;
                end
                seen  <= '0;
                ferr  <= 1'b0;
                state <= IDLE;
            end else begin
                seen <= seen_n;
                ferr <= ferr_n;
                case (state)
                    IDLE:    if (capture) state <= COLLECT;
                    COLLECT: state <= COLLECT;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// tb/tb_sevenseg_scan_decoder.sv - scoreboard bench for sevenseg_scan_decoder
module tb_sevenseg_scan_decoder;

    localparam int DIGITS = 4;
    localparam int STABLE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  segments;
    logic [3:0]  digit_sel;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_err;
    logic        overrun;

    int errors   = 0;
    int checks   = 0;
    int overruns = 0;
    int frames   = 0;
    logic [16:0] sb[$];

    sevenseg_scan_decoder #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .segments  (segments),
        .digit_sel (digit_sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_err   (out_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (overrun === 1'b1)
            overruns++;
        if (!rst && out_valid && out_ready) begin
            logic [16:0] e;
            frames++;
            check("frame_pending", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("frame_data", out_data, e[15:0]);
                check("frame_err", out_err, e[16]);
            end
        end
    end

    task automatic drive(input logic [3:0] sel, input logic [6:0] seg, input int n);
        digit_sel = sel;
        segments  = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // pats = {digit3, digit2, digit1, digit0}
    task automatic scan(input logic [27:0] pats, input int n);
        for (int i = 0; i < DIGITS; i++)
            drive(4'(1 << i), pats[7*i +: 7], n);
        drive(4'h0, 7'h00, 2);
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(tag, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int f, o, k;
        rst = 1'b1; out_ready = 1'b1; digit_sel = 4'h0; segments = 7'h00;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_err", out_err, 0);
        check("rst_overrun", overrun, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1,2,3,4 held 4 cycles each
        sb.push_back({1'b0, 16'h4321});
        scan({7'h33, 7'h79, 7'h6D, 7'h30}, 4);
        wait_drain("t1_drain");
        check("t1_frames", frames, 1);

        // latency of the last digit
        sb.push_back({1'b0, 16'h4321});
        drive(4'h1, 7'h30, 4);
        drive(4'h2, 7'h6D, 4);
        drive(4'h4, 7'h79, 4);
        digit_sel = 4'h8; segments = 7'h33;
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("latency", k, STABLE + 1);
        drive(4'h0, 7'h00, 2);
        wait_drain("t1b_drain");

        // holds shorter than STABLE never capture
        f = frames;
        scan({7'h33, 7'h79, 7'h6D, 7'h30}, 2);
        repeat (5) @(posedge clk);
        #1;
        check("short_frames", frames, f);
        check("short_valid", out_valid, 0);

        // invalid pattern on digit 2
        sb.push_back({1'b1, 16'hFE50});
        scan({7'h00, 7'h7C, 7'h5B, 7'h7E}, 4);
        wait_drain("t3_drain");

        // multi-hot glitch mid-scan
        sb.push_back({1'b0, 16'h6789});
        drive(4'h1, 7'h7B, 4);
        drive(4'h3, 7'h7F, 5);
        drive(4'h2, 7'h7F, 4);
        drive(4'h4, 7'h70, 4);
        drive(4'h8, 7'h5F, 4);
        drive(4'h0, 7'h00, 2);
        wait_drain("t4_drain");

        // back-pressure: second frame dropped with overrun
        out_ready = 1'b0;
        o = overruns;
        sb.push_back({1'b0, 16'h4321});
        scan({7'h33, 7'h79, 7'h6D, 7'h30}, 4);
        check("bp_valid1", out_valid, 1);
        check("bp_data1", out_data, 16'h4321);
        scan({7'h7F, 7'h70, 7'h5F, 7'h5B}, 4);
        check("bp_overrun", overruns - o, 1);
        check("bp_data2", out_data, 16'h4321);
        check("bp_valid2", out_valid, 1);
        check("bp_err2", out_err, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", out_valid, 0);
        check("bp_sb_empty", sb.size(), 0);

        // reset after two captures
        drive(4'h1, 7'h30, 4);
        drive(4'h2, 7'h6D, 4);
        digit_sel = 4'h4; segments = 7'h79;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_data", out_data, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_err", out_err, 0);
        check("mid_rst_overrun", overrun, 0);
        digit_sel = 4'h0; segments = 7'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.push_back({1'b0, 16'h0000});
        scan({7'h7E, 7'h7E, 7'h7E, 7'h7E}, 4);
        wait_drain("t6_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
